// File: rtl/mem_stream_reader.sv
// mem_stream_reader: sequential read master for a synchronous memory with a
// 1-cycle registered read. It walks addresses from start_addr for len words,
// wrapping at DEPTH, and presents the data as a valid/ready stream. A 2-entry
// output buffer absorbs the read latency. The read-ahead is bounded so that
// downstream backpressure never loses or duplicates a word.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | waiting for start; command inputs sampled only here
//  ST_RUN  | issuing reads and streaming words until the last one pops
//  ST_ZERO | len == 0 command; single done cycle, no stream beats
module mem_stream_reader #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    read_addr,
    input  logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   REM_ONE   = {{AW{1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_next;
    logic [AW:0]      remaining_q;
    logic             inflight_q;
    logic [1:0]       count_q;
    logic [WIDTH-1:0] buf0_q;
    logic [WIDTH-1:0] buf1_q;

    logic             cmd_accept;
    logic             pop;
    logic             push;
    logic             issue;
    logic             last_pop;
    logic [2:0]       credit_used;

    assign busy      = (state_q != ST_IDLE);
    assign read_addr = addr_q;
    assign out_data  = buf0_q;
    assign out_valid = (count_q != 2'd0);

    // Stream handshake, buffer credit and issue decision.
    always_comb begin
        pop         = out_valid && out_ready;
        push        = inflight_q;
        // Words already owned by the buffer or still coming out of mem,
        // minus the one leaving this cycle. Never underflows: pop needs count >= 1.
        credit_used = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue       = (state_q == ST_RUN) && (remaining_q != '0) && (credit_used < 3'd2);
        // The final word is the only one left anywhere: nothing to issue,
        // nothing in flight, and it is the sole buffered entry.
        last_pop    = (state_q == ST_RUN) && pop && (count_q == 2'd1)
                      && !inflight_q && (remaining_q == '0);
        addr_next   = (addr_q == LAST_ADDR) ? '0 : (addr_q + ADDR_ONE);
    end

    // Next-state and command/done decode.
    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_accept = 1'b1;
                    state_d    = (len == '0) ? ST_ZERO : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_pop) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ZERO: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read address walker and remaining-word down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (cmd_accept) begin
            addr_q      <= start_addr;
            remaining_q <= len;
        end else if (issue) begin
            addr_q      <= addr_next;
            remaining_q <= remaining_q - REM_ONE;
        end
    end

    // A read issued this cycle returns data on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
        end
    end

    // Two-entry FIFO: buf0 is the head shown on out_data, buf1 the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q  <= '0;
            buf1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        buf0_q <= read_data;
                    end else begin
                        buf1_q <= read_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        buf0_q <= read_data;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: models the synchronous memory, drives commands
// and out_ready patterns, and compares the stream against an expected word
// queue built from the memory contents and address arithmetic.
module tb_mem_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      len;
    logic             busy;
    logic             done;
    logic [AW-1:0]    read_addr;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory with one cycle of latency.
    always @(posedge clk) read_data <= mem[read_addr];

    mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random.
    task automatic run_stream(input int sa, input int ln, input int mode, input bit second_start);
        logic [WIDTH-1:0] expq[$];
        logic [WIDTH-1:0] exp_word;
        logic [WIDTH-1:0] prev_data;
        logic [AW-1:0]    prev_addr;
        bit               prev_stall;
        bit               finished;
        bit               pop;
        bit               exp_done;
        bit               exp_valid;
        int               popped;
        int               issued;
        int               budget;
        int               exp_a;
        int               pat[6] = '{1, 0, 0, 1, 0, 1};
        for (int i = 0; i < ln; i++) expq.push_back(mem[(sa + i) % DEPTH]);
        popped     = 0;
        issued     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_addr  = '0;
        finished   = 1'b0;
        budget     = 8 * ln + 40;
        @(negedge clk);
        start      = 1'b1;
        start_addr = sa[AW-1:0];
        len        = ln[AW:0];
        out_ready  = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat[(k - 1) % 6] != 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (second_start && k == 4) begin
                start      = 1'b1;
                start_addr = 8'd100;
                len        = 9'd7;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_run: k=%0d got %b expected 1", k, busy);
            end
            if (k == 1) begin
                checks++;
                if (int'(read_addr) != sa) begin
                    errors++;
                    $display("FAIL first_read_addr: got %0d expected %0d", read_addr, sa);
                end
            end else if (read_addr != prev_addr) begin
                exp_a = (int'(prev_addr) + 1) % DEPTH;
                issued++;
                checks++;
                if (int'(read_addr) != exp_a) begin
                    errors++;
                    $display("FAIL addr_step: got %0d expected %0d", read_addr, exp_a);
                end
            end
            prev_addr = read_addr;
            checks++;
            if (issued - popped > 2 || issued > ln) begin
                errors++;
                $display("FAIL read_ahead: issued %0d popped %0d len %0d (allowed ahead 2)", issued, popped, ln);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b data=%0h expected valid=1 data=%0h",
                             out_valid, out_data, prev_data);
                end
            end
            if (mode == 0) begin
                exp_valid = (k >= 3) && (k < 3 + ln);
                checks++;
                if (out_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL valid_timing: k=%0d got %b expected %b", k, out_valid, exp_valid);
                end
            end
            pop = (out_valid === 1'b1) && out_ready;
            if (pop) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got data %0h expected no beat", out_data);
                end else begin
                    exp_word = expq.pop_front();
                    if (out_data !== exp_word) begin
                        errors++;
                        $display("FAIL beat_data: beat %0d got %0h expected %0h", popped, out_data, exp_word);
                    end
                end
                popped++;
            end
            exp_done = pop && (popped == ln);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done_pulse: k=%0d got %b expected %b", k, done, exp_done);
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            if (exp_done) begin
                finished = 1'b1;
                break;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", popped, ln);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_done_idle: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        out_ready  = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || read_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b addr=%0d data=%0h expected all 0",
                     busy, done, out_valid, read_addr, out_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b expected 0", busy, out_valid, done);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem[4 + i] = 32'(10 + i);
        run_stream(4, 4, 0, 1'b0);
    endtask

    task automatic test_wrap();
        mem[254] = 32'd7;
        mem[255] = 32'd8;
        mem[0]   = 32'd9;
        run_stream(254, 3, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) mem[20 + i] = 32'(1 + i);
        run_stream(20, 6, 1, 1'b0);
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start      = 1'b1;
        start_addr = 8'd33;
        len        = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: got done=%b busy=%b valid=%b expected 1 1 0", done, busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL len0_after: cycle %0d got done=%b busy=%b valid=%b expected 0 0 0",
                         i, done, busy, out_valid);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_stream(60, 4, 0, 1'b1);
    endtask

    task automatic test_reset_mid_stream();
        int popped;
        bit pop;
        popped = 0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = 8'd40;
        len        = 9'd5;
        out_ready  = 1'b1;
        for (int k = 0; k < 12 && popped < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            pop = (out_valid === 1'b1);
            if (pop) begin
                checks++;
                if (out_data !== mem[40 + popped] || done !== 1'b0) begin
                    errors++;
                    $display("FAIL pre_reset_beat: got data=%0h done=%b expected data=%0h done=0",
                             out_data, done, mem[40 + popped]);
                end
                popped++;
            end
        end
        checks++;
        if (popped != 2) begin
            errors++;
            $display("FAIL pre_reset_timeout: got %0d beats expected 2", popped);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || read_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b addr=%0d data=%0h expected all 0",
                     busy, done, out_valid, read_addr, out_data);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got done=%b valid=%b expected 0 0", done, out_valid);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(int'($urandom_range(0, DEPTH - 1)), 5, 0, 1'b0);
    endtask

    task automatic test_throughput();
        run_stream(0, 256, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            run_stream(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 300)), 2, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid_stream();
        test_throughput();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
